// File: rtl/as1802_uart.sv
// as1802 UART: byte-wide 8N1 serial transceiver, LSB first, programmable bit period.
// TX and RX run as independent state machines; the RX pad is synchronized before use.
module as1802_uart #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        TX,
    input  logic        RX,
    input  logic        start,
    output logic        busy,
    output logic        has_byte,
    input  logic        clr_hb,
    output logic        overrun,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [15:0]            period_s;
    logic                   rxs_s;
    logic [SYNC_STAGES-1:0] rx_sync_r;

    state_t      tx_state_r;
    logic [15:0] tx_p_r;
    logic [15:0] tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;

    state_t      rx_state_r;
    logic [15:0] rx_p_r;
    logic [15:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;

    // Effective bit period: anything below two cycles cannot be centre-sampled.
    always_comb begin
        if (divisor < 16'd2) begin
            period_s = 16'd2;
        end else begin
            period_s = divisor;
        end
    end

    assign rxs_s = rx_sync_r[SYNC_STAGES-1];

    // RX pad synchronizer chain, idles high like the line itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            rx_sync_r <= {rx_sync_r[SYNC_STAGES-2:0], RX};
        end
    end

    // Transmit FSM: each bit is held for exactly tx_p_r cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= ST_IDLE;
            tx_p_r     <= 16'd0;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            TX         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (tx_state_r)
                ST_IDLE: begin
                    TX   <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        tx_state_r <= ST_START;
                        tx_p_r     <= period_s;
                        tx_cnt_r   <= period_s - 16'd1;
                        tx_shift_r <= din;
                        TX         <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_cnt_r == 16'd0) begin
                        tx_state_r <= ST_DATA;
                        tx_cnt_r   <= tx_p_r - 16'd1;
                        tx_bit_r   <= 3'd0;
                        TX         <= tx_shift_r[0];
                    end else begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_r == 16'd0) begin
                        tx_cnt_r <= tx_p_r - 16'd1;
                        if (tx_bit_r == 3'd7) begin
                            tx_state_r <= ST_STOP;
                            TX         <= 1'b1;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            TX         <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_r == 16'd0) begin
                        tx_state_r <= ST_IDLE;
                        busy       <= 1'b0;
                    end else begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    TX         <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Receive FSM: half-period to the start-bit centre, then one full period per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= ST_IDLE;
            rx_p_r     <= 16'd0;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            dout       <= 8'd0;
            has_byte   <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (clr_hb) begin
                has_byte <= 1'b0;
                overrun  <= 1'b0;
            end
            case (rx_state_r)
                ST_IDLE: begin
                    if (!rxs_s) begin
                        rx_state_r <= ST_START;
                        rx_p_r     <= period_s;
                        rx_cnt_r   <= (period_s >> 1) - 16'd1;
                    end
                end
                ST_START: begin
                    if (rx_cnt_r == 16'd0) begin
                        if (rxs_s) begin
                            rx_state_r <= ST_IDLE;
                        end else begin
                            rx_state_r <= ST_DATA;
                            rx_cnt_r   <= rx_p_r - 16'd1;
                            rx_bit_r   <= 3'd0;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_r == 16'd0) begin
                        rx_shift_r <= {rxs_s, rx_shift_r[7:1]};
                        rx_cnt_r   <= rx_p_r - 16'd1;
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= ST_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_r == 16'd0) begin
                        rx_state_r <= ST_IDLE;
                        if (rxs_s) begin
                            // A capture overrides a coincident clr_hb on has_byte.
                            dout     <= rx_shift_r;
                            has_byte <= 1'b1;
                            if (has_byte && !clr_hb) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                default: begin
                    rx_state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_as1802_uart.sv
// Self-checking bench for as1802_uart: a frame-level TX model compared every cycle,
// plus a per-frame RX outcome model and hand-computed directed expectations.
module tb_as1802_uart;

    logic        clk = 1'b0;
    logic        rst, start, clr_hb, loop_en, rx_drv;
    logic        RX;
    logic [15:0] divisor;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        TX, busy, has_byte, overrun, frame_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;
    assign RX = loop_en ? TX : rx_drv;

    as1802_uart #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .divisor(divisor), .din(din), .dout(dout),
        .TX(TX), .RX(RX), .start(start), .busy(busy), .has_byte(has_byte),
        .clr_hb(clr_hb), .overrun(overrun), .frame_err(frame_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic int eff_p(input logic [15:0] d);
        return (d < 16'd2) ? 2 : int'(d);
    endfunction

    // TX reference: a frame accepted at edge m_s is the 10-bit word held m_p cycles per bit.
    int         edge_n   = 0;
    int         m_s      = 0;
    int         m_p      = 2;
    logic       m_active = 1'b0;
    logic       m_valid  = 1'b0;
    logic [9:0] m_frame  = 10'h3ff;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_valid  <= 1'b1;
        end else if (start && !(m_active && (edge_n - m_s) < 10 * m_p)) begin
            m_active <= 1'b1;
            m_s      <= edge_n + 1;
            m_p      <= eff_p(divisor);
            m_frame  <= {1'b1, din, 1'b0};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            if (m_active && (edge_n - m_s) < 10 * m_p) begin
                check("model_busy", busy, 1);
                check("model_tx", TX, m_frame[(edge_n - m_s) / m_p]);
            end else begin
                check("model_busy", busy, 0);
                check("model_tx", TX, 1);
            end
        end
    end

    int ferr_seen = 0;
    always @(negedge clk) begin
        if (m_valid && frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
    end

    // RX outcome model
    logic       e_has  = 1'b0;
    logic       e_ov   = 1'b0;
    logic [7:0] e_dout = 8'h00;
    int         e_ferr = 0;

    task automatic tx_literal(input logic [15:0] div, input logic [7:0] b,
                              input logic [9:0] bits, input int p, input int exp_busy);
        int bcnt;
        divisor = div;
        din     = b;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcnt  = 0;
        check("tx_first_low", TX, 0);
        for (int k = 0; k < exp_busy + 4; k++) begin
            if (busy === 1'b1) bcnt++;
            if (k < exp_busy && (k % p) == (p / 2)) check("tx_bit", TX, bits[k / p]);
            @(negedge clk);
        end
        check("tx_busy_len", bcnt, exp_busy);
    endtask

    task automatic send_rx(input logic [7:0] b, input int p, input logic stop_lvl);
        logic [9:0] f;
        f = {stop_lvl, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rx_drv = f[j];
            repeat (p) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic [15:0] div,
                            input logic stop_ok, input logic do_clr);
        divisor = div;
        if (do_clr) begin
            clr_hb = 1'b1;
            @(negedge clk);
            clr_hb = 1'b0;
            e_has = 1'b0;
            e_ov  = 1'b0;
        end
        send_rx(b, eff_p(div), stop_ok);
        if (stop_ok) begin
            e_ov   = e_ov | e_has;
            e_has  = 1'b1;
            e_dout = b;
        end else begin
            e_ferr++;
        end
        repeat (2 * eff_p(div) + 6) @(negedge clk);
        check("rx_has", has_byte, e_has);
        check("rx_dout", dout, e_dout);
        check("rx_overrun", overrun, e_ov);
        check("rx_ferr_count", ferr_seen, e_ferr);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int lat;
        rst = 1'b1; start = 1'b0; clr_hb = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
        divisor = 16'd16; din = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx", TX, 1);
        check("rst_busy", busy, 0);
        check("rst_has", has_byte, 0);
        check("rst_ovr", overrun, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_dout", dout, 8'h00);

        // Directed TX frames with hand-written bit patterns (start..stop, LSB index first).
        tx_literal(16'd16, 8'hA5, 10'b1101001010, 16, 160);
        tx_literal(16'd0, 8'h3C, 10'b1001111000, 2, 20);

        // Random TX traffic: starts while busy and divisor changes mid-frame.
        for (int c = 0; c < 2500; c++) begin
            start = ($urandom_range(0, 9) == 0);
            din   = 8'($urandom);
            if ($urandom_range(0, 59) == 0) divisor = 16'($urandom_range(0, 12));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (200) @(negedge clk);

        // Loopback at P=10.
        loop_en = 1'b1;
        divisor = 16'd10;
        din     = 8'h3C;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (has_byte !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("lb_latency_in_range", (k >= 90 && k <= 105), 1);
        check("lb_dout", dout, 8'h3C);
        check("lb_has", has_byte, 1);
        clr_hb = 1'b1;
        @(negedge clk);
        clr_hb = 1'b0;
        check("lb_clr_has", has_byte, 0);
        repeat (120) @(negedge clk);
        loop_en = 1'b0;
        e_has = 1'b0; e_ov = 1'b0; e_dout = 8'h3C;

        // Short glitch must not start a frame.
        divisor = 16'd16;
        rx_drv  = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_has", has_byte, 0);
        check("glitch_ferr_count", ferr_seen, e_ferr);
        rx_frame(8'h81, 16'd16, 1'b1, 1'b0);
        check("rx81_dout", dout, 8'h81);

        // Bad stop bit.
        rx_frame(8'h55, 16'd16, 1'b0, 1'b1);
        check("ferr_has", has_byte, 0);
        check("ferr_dout", dout, 8'h81);

        // Overrun, then clr_hb coinciding with a capture.
        rx_frame(8'h11, 16'd16, 1'b1, 1'b1);
        lat = 0;
        fork
            send_rx(8'h22, 16, 1'b1);
            begin
                while (dout !== 8'h22 && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("ovr_latency_bound", (lat >= 144 && lat <= 170), 1);
        repeat (40) @(negedge clk);
        check("ovr_dout", dout, 8'h22);
        check("ovr_flag", overrun, 1);
        check("ovr_has", has_byte, 1);
        fork
            send_rx(8'h33, 16, 1'b1);
            begin
                repeat (lat - 1) @(negedge clk);
                clr_hb = 1'b1;
                @(negedge clk);
                clr_hb = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        check("clrcap_has", has_byte, 1);
        check("clrcap_ovr", overrun, 0);
        check("clrcap_dout", dout, 8'h33);

        // Reset mid-frame on both TX and RX (looped back).
        loop_en = 1'b1;
        divisor = 16'd16;
        din     = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx", TX, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_has", has_byte, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_dout", dout, 8'h00);
        repeat (200) @(negedge clk);
        check("post_rst_has", has_byte, 0);
        check("post_rst_ferr_count", ferr_seen, e_ferr);
        loop_en = 1'b0;
        e_has = 1'b0; e_ov = 1'b0; e_dout = 8'h00;

        // Random RX frames.
        for (int f = 0; f < 12; f++) begin
            rx_frame(8'($urandom), 16'($urandom_range(0, 24)),
                     ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/as1802_uart.md
Name: as1802_uart

Overview:
- Byte-wide asynchronous serial transceiver: 8N1 framing, LSB first, programmable bit period.
- Sits directly behind the as1802 core's I/O page at 0xFFF0-0xFFF3.
- The core writes the divisor and the transmit byte (D via B), pulses `start`, polls `busy` and `has_byte`, reads `dout`, and pulses `clr_hb` on data read.
- Drives the TX pad and samples the RX pad.

Parameters:
- SYNC_STAGES, 2, number of RX input synchronizer flops (≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- divisor  input  16  bit period in clk cycles; values 0 or 1 are treated as 2.
- din  input  8  transmit byte, sampled on the `start` cycle only.
- dout  output  8  last correctly framed received byte.
- TX  output  1  serial out; idle high.
- RX  input  1  serial in; asynchronous to clk.
- start  input  1  one-cycle request to transmit `din`.
- busy  output  1  high while a TX frame is in progress.
- has_byte  output  1  sticky: a received byte is waiting.
- clr_hb  input  1  one-cycle clear of `has_byte` and `overrun`.
- overrun  output  1  sticky: a byte was received while `has_byte` was already set.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on posedge clk.
  - rst=1 at any edge, including mid-frame: TX=1, busy=0, has_byte=0, overrun=0, frame_err=0, dout=0x00, both FSMs → IDLE, counters cleared.
- Effective period P = (divisor<2) ? 2 : divisor.
  - P is latched separately into the TX and RX FSMs at frame start.
  - Divisor writes mid-frame do not affect the current frame.
- TX FSM: IDLE → START → DATA(0..7) → STOP → IDLE.
  - IDLE: TX=1, busy=0.
  - start=1 in IDLE: latch din and P; at the next edge enter START with TX=0 and busy=1. Latency: start cycle N gives TX low from cycle N+1.
  - Each bit holds exactly P cycles. DATA bit i drives din[i]. STOP drives 1 for P cycles.
  - busy falls at the same edge STOP ends, so busy is high for exactly 10·P cycles.
  - start while busy=1 is ignored. No queueing; `din` is not re-sampled.
  - A start asserted on the same cycle busy falls is also ignored. busy must be seen low before start.
- RX path: RX passes through SYNC_STAGES flops, giving rxs (reset value 1).
- RX FSM: IDLE → START → DATA(0..7) → STOP → IDLE.
  - IDLE: wait for rxs=0. On detection, latch P and load counter P/2 (integer divide).
  - START: at the count end re-sample rxs.
    - rxs=1: glitch, return to IDLE, no flags.
    - rxs=0: reload P.
  - DATA: sample rxs every P cycles into a shift register, LSB first.
  - STOP: sample after P cycles.
    - rxs=1: dout ← byte and has_byte ← 1 on the same edge. If has_byte was already 1 and clr_hb is not asserted that cycle, overrun ← 1.
    - rxs=0: dout and has_byte unchanged; frame_err pulses for 1 cycle.
  - Return to IDLE on the edge after the stop sample. A new falling edge may then be detected immediately (back-to-back frames).
- clr_hb: at the next edge has_byte ← 0 and overrun ← 0.
  - If clr_hb coincides with a valid stop-bit capture, the capture wins: has_byte=1, overrun=0.
- TX and RX are fully independent. Loopback (RX tied to TX) must work at any P ≥ 2.

Test Plan:
- Reset, then divisor=16, start with din=0xA5 → TX low at cycle +1 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, stop high for 16 cycles; busy high for exactly 160 cycles.
- Loopback with divisor=10: send 0x3C → has_byte=1 with dout=0x3C about 95 cycles after start (the stop-bit sample). Pulse clr_hb → has_byte=0 next cycle.
- RX low pulse of 3 cycles with divisor=16 → no has_byte, no frame_err, FSM back in IDLE. A following valid 0x81 frame is received correctly.
- Inject frame 0x55 with stop bit held low → frame_err pulses once; has_byte stays 0; dout unchanged.
- Two frames 0x11 then 0x22 with no clr_hb → dout=0x22, overrun=1. clr_hb on the cycle of a third capture (0x33) → has_byte=1, overrun=0, dout=0x33.
- Reset midway through a TX of 0xFF and midway through an RX → next cycle TX=1, busy=0, has_byte=0. start while busy is ignored. divisor=0 gives a 2-cycle bit period.
